// File: rtl/mat_pkg.sv
// mat_pkg: FSM state type and signed saturation bounds shared by mat_sub_seq.
// Exports: state_t (IDLE/RUN/DRAIN/DONE), wide_t, sat_max(w), sat_min(w).
// sat_max/sat_min give the largest/smallest signed value of a w-bit word,
// sign-extended to MAX_W bits; callers slice off the low w bits.
package mat_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int MAX_W = 64;
  typedef logic signed [MAX_W-1:0] wide_t;
  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction
  function automatic wide_t sat_min(input int w);
    return ~sat_max(w);
  endfunction
endpackage

// File: rtl/mat_sub_seq_if.sv
// mat_sub_seq_if: control, element-read and result-write signals of mat_sub_seq.
// slave = the sequencer (drives status, read strobe/address, write port);
// master = the environment (drives start/abort and the A/B read data).
interface mat_sub_seq_if #(parameter int DATA_W = 32, parameter int ADDR_W = 6);
  logic start, abort, busy, done, ovf, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data;
  modport master(output start, abort, rd_data_a, rd_data_b,
                 input busy, done, ovf, rd_en, rd_addr, wr_en, wr_addr, wr_data);
  modport slave(input start, abort, rd_data_a, rd_data_b,
                output busy, done, ovf, rd_en, rd_addr, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/mat_sub_elem.sv
// mat_sub_elem: one registered signed element subtract out_data = a - b.
// Ports: clk, rst_n (async, active-low), clr (drop the element in flight),
// in_valid/in_addr/a/b in; out_valid/out_addr/out_data/out_ovf registered out.
// MAT_SUB_SAT_EN defined: overflowing results clamp to the signed max/min;
// otherwise they wrap modulo 2^DATA_W. out_ovf flags overflow either way.
module mat_sub_elem #(parameter int DATA_W = 32, parameter int ADDR_W = 6) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic              out_ovf,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);
  import mat_pkg::*;
  logic [DATA_W:0] diff;
  logic [DATA_W-1:0] res;
  logic ovf;
  // one extra bit holds the exact difference; top two bits disagree on overflow
  assign diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
  assign ovf = diff[DATA_W] ^ diff[DATA_W-1];
`ifdef MAT_SUB_SAT_EN
  localparam wide_t SMAX = sat_max(DATA_W);
  localparam wide_t SMIN = sat_min(DATA_W);
  assign res = ovf ? (diff[DATA_W] ? SMIN[DATA_W-1:0] : SMAX[DATA_W-1:0]) : diff[DATA_W-1:0];
`else
  assign res = diff[DATA_W-1:0];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ovf <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_valid <= in_valid && !clr;
      if (in_valid) begin
        out_addr <= in_addr;
        out_data <= res;
        out_ovf <= ovf;
      end
    end
endmodule

// File: rtl/mat_sub_seq.sv
// mat_sub_seq: streams C = A - B over a SIZE_A x SIZE_B signed matrix.
// Ports: clk, rst_n (async, active-low), bus (mat_sub_seq_if.slave):
// start/abort control, busy/done/ovf status, rd_en/rd_addr to the A/B
// memories (data one cycle later), wr_en/wr_addr/wr_data result port.
// Timing: reads at cycles 1..N after start, writes at 3..N+2, done at N+3.
// Optional macro MAT_SUB_SAT_EN selects saturating instead of wrapping results.
module mat_sub_seq #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  mat_sub_seq_if.slave bus
);
  import mat_pkg::*;
  localparam int N = SIZE_A * SIZE_B;
  localparam int ADDR_W = N > 1 ? $clog2(N) : 1;
  state_t state, nxt;
  logic [ADDR_W-1:0] cnt, a1;
  logic v1, d, s, last, go, w_ovf;
  assign last = cnt == ADDR_W'(N - 1);
  assign go = state == IDLE && bus.start;
  assign bus.rd_en = state == RUN;
  assign bus.rd_addr = cnt;
  assign bus.busy = state == RUN || state == DRAIN;
  assign bus.done = state == DONE;
  // sticky flag plus the element being written this cycle, so ovf rises with its write
  assign bus.ovf = s || (bus.wr_en && w_ovf);
  always_comb
    nxt = (state != IDLE && bus.abort) ? IDLE :
          state == IDLE  ? (bus.start ? RUN : IDLE) :
          state == RUN   ? (last ? DRAIN : RUN) :
          state == DRAIN ? (d ? DONE : DRAIN) : IDLE;
  // d marks the second DRAIN cycle, when the last element is written
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a1 <= '0;
      v1 <= 1'b0;
      d <= 1'b0;
      s <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= go ? '0 : (bus.rd_en && !last) ? cnt + 1'b1 : cnt;
      a1 <= cnt;
      v1 <= bus.rd_en && !bus.abort;
      d <= state == DRAIN;
      s <= go ? 1'b0 : bus.ovf;
    end
  mat_sub_elem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_elem (
    .clk(clk),
    .rst_n(rst_n),
    .clr(bus.abort),
    .in_valid(v1),
    .in_addr(a1),
    .a(bus.rd_data_a),
    .b(bus.rd_data_b),
    .out_valid(bus.wr_en),
    .out_ovf(w_ovf),
    .out_addr(bus.wr_addr),
    .out_data(bus.wr_data)
  );
endmodule

// File: tb/tb_mat_sub_seq.sv
// tb_mat_sub_seq: directed bench for mat_sub_seq (2x2/8-bit and 8x8/32-bit instances).
module tb_mat_sub_seq;
  localparam int N = 64;
  logic clk, rst_n;
  int cyc, checks, errors, m_t0, m_end, t0, nwr, done_cyc;
  bit chk_en, e_ovf;
  logic [31:0] cap40;
  int ma [N];
  int mb [N];
  logic signed [7:0] sa [4];
  logic signed [7:0] sb [4];

  mat_sub_seq_if #(.DATA_W(32), .ADDR_W(6)) bl();
  mat_sub_seq_if #(.DATA_W(8), .ADDR_W(2)) bs();

  mat_sub_seq #(.SIZE_A(8), .SIZE_B(8), .DATA_W(32)) u_l (.clk(clk), .rst_n(rst_n), .bus(bl.slave));
  mat_sub_seq #(.SIZE_A(2), .SIZE_B(2), .DATA_W(8)) u_s (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) if (bl.rd_en) begin
    bl.rd_data_a <= ma[bl.rd_addr];
    bl.rd_data_b <= mb[bl.rd_addr];
  end
  always @(posedge clk) if (bs.rd_en) begin
    bs.rd_data_a <= sa[bs.rd_addr];
    bs.rd_data_b <= sb[bs.rd_addr];
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic longint full_diff(input int k);
    return longint'(ma[k]) - longint'(mb[k]);
  endfunction
  function automatic bit e_ovf_of(input int k);
    return full_diff(k) > 64'sd2147483647 || full_diff(k) < -64'sd2147483648;
  endfunction
  function automatic logic [31:0] e_val(input int k);
    longint f = full_diff(k);
`ifdef MAT_SUB_SAT_EN
    if (f > 64'sd2147483647) return 32'h7fffffff;
    if (f < -64'sd2147483648) return 32'h80000000;
`endif
    return f[31:0];
  endfunction

  always @(negedge clk) begin
    if (bl.done) done_cyc = cyc;
    if (bl.wr_en) begin
      nwr++;
      if (bl.wr_addr == 6'd40) cap40 = bl.wr_data;
    end
  end

  // model: a live pass started at m_t0 reads 1..N, writes 3..N+2, done N+3, cut at m_end
  always @(negedge clk) if (chk_en) begin
    int d;
    bit live, ew;
    d = cyc - m_t0;
    live = m_t0 >= 0 && cyc <= m_end && d >= 1;
    ew = live && d >= 3 && d <= N + 2;
    if (live && d == 1) e_ovf = 1'b0;
    if (ew && e_ovf_of(d - 3)) e_ovf = 1'b1;
    chk("busy", 64'(bl.busy), 64'(live && d <= N + 2));
    chk("done", 64'(bl.done), 64'(live && d == N + 3));
    chk("rd_en", 64'(bl.rd_en), 64'(live && d <= N));
    chk("wr_en", 64'(bl.wr_en), 64'(ew));
    chk("ovf", 64'(bl.ovf), 64'(e_ovf));
    if (live && d <= N) chk("rd_addr", 64'(bl.rd_addr), 64'(d - 1));
    if (ew) begin
      chk("wr_addr", 64'(bl.wr_addr), 64'(d - 3));
      chk("wr_data", 64'(bl.wr_data), 64'(e_val(d - 3)));
    end
  end

  task automatic start_l();
    @(posedge clk);
    #1;
    bl.start = 1'b1;
    if (m_t0 < 0 || cyc > m_end) begin
      m_t0 = cyc;
      m_end = cyc + N + 3;
    end
    @(posedge clk);
    #1;
    bl.start = 1'b0;
  endtask

  task automatic run_small(input logic [31:0] ev, input bit eovf);
    @(posedge clk);
    #1;
    bs.start = 1'b1;
    @(posedge clk);
    #1;
    bs.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("s_busy", 64'(bs.busy), 64'(k <= 6));
      chk("s_done", 64'(bs.done), 64'(k == 7));
      chk("s_wr_en", 64'(bs.wr_en), 64'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        chk("s_wr_addr", 64'(bs.wr_addr), 64'(k - 3));
        chk("s_wr_data", 64'(bs.wr_data), 64'(ev[8*(k-3) +: 8]));
      end
    end
    chk("s_ovf", 64'(bs.ovf), 64'(eovf));
  endtask

  initial begin
    rst_n = 1'b0;
    bl.start = 1'b0; bl.abort = 1'b0; bs.start = 1'b0; bs.abort = 1'b0;
    cyc = 0; checks = 0; errors = 0; m_t0 = -1; m_end = -1; e_ovf = 1'b0; chk_en = 1'b0;
    nwr = 0; done_cyc = -1; cap40 = '0;
    for (int k = 0; k < N; k++) begin
      ma[k] = k * 1000 - 30000;
      mb[k] = 5 - 37 * k;
    end
    ma[40] = 2147483647; mb[40] = -5;
    ma[41] = int'(32'h80000000); mb[41] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bl.busy), 64'(0));
    chk("rst_done", 64'(bl.done), 64'(0));
    chk("rst_ovf", 64'(bl.ovf), 64'(0));
    chk("rst_rd_en", 64'(bl.rd_en), 64'(0));
    chk("rst_wr_en", 64'(bl.wr_en), 64'(0));
    chk("rst_addrs", 64'({bl.rd_addr, bl.wr_addr}), 64'(0));
    chk("rst_wr_data", 64'(bl.wr_data), 64'(0));
    rst_n = 1'b1;
    chk_en = 1'b1;
    sa = '{8'sd5, 8'sd7, 8'sd9, 8'sd11};
    sb = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    run_small({8'd7, 8'd6, 8'd5, 8'd4}, 1'b0);
    sa = '{8'sd127, 8'sd0, 8'sd0, 8'sd0};
    sb = '{-8'sd1, 8'sd0, 8'sd0, 8'sd0};
`ifdef MAT_SUB_SAT_EN
    run_small({24'd0, 8'h7f}, 1'b1);
`else
    run_small({24'd0, 8'h80}, 1'b1);
`endif
    nwr = 0; done_cyc = -1;
    start_l();
    t0 = m_t0;
    start_l();
    repeat (70) @(posedge clk);
    #1;
    chk("restart_writes", 64'(nwr), 64'(64));
    chk("restart_done_lat", 64'(done_cyc - t0), 64'(67));
    chk("pass_ovf_sticky", 64'(bl.ovf), 64'(1));
`ifdef MAT_SUB_SAT_EN
    chk("elem40", 64'(cap40), 64'(32'h7fffffff));
`else
    chk("elem40", 64'(cap40), 64'(32'h80000004));
`endif
    nwr = 0; done_cyc = -1;
    start_l();
    t0 = m_t0;
    repeat (9) @(posedge clk);
    #1;
    bl.abort = 1'b1;
    m_end = cyc;
    @(posedge clk);
    #1;
    bl.abort = 1'b0;
    chk("abort_cycle", 64'(cyc - t0), 64'(11));
    chk("abort_busy", 64'(bl.busy), 64'(0));
    repeat (70) @(posedge clk);
    #1;
    chk("abort_writes", 64'(nwr), 64'(8));
    chk("abort_no_done", 64'(done_cyc == -1), 64'(1));
    chk("abort_ovf_cleared", 64'(bl.ovf), 64'(0));
    nwr = 0; done_cyc = -1;
    start_l();
    t0 = m_t0;
    repeat (70) @(posedge clk);
    #1;
    chk("clean_writes", 64'(nwr), 64'(64));
    chk("clean_done_lat", 64'(done_cyc - t0), 64'(67));
    start_l();
    t0 = m_t0;
    repeat (19) @(posedge clk);
    #2;
    chk("pre_rst_wr_en", 64'(bl.wr_en), 64'(1));
    rst_n = 1'b0;
    m_t0 = -1; m_end = -1; e_ovf = 1'b0;
    #1;
    chk("arst_outs", 64'({bl.busy, bl.done, bl.ovf, bl.rd_en, bl.wr_en}), 64'(0));
    chk("arst_data", 64'({bl.wr_data, bl.wr_addr, bl.rd_addr}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nwr = 0; done_cyc = -1;
    repeat (80) @(posedge clk);
    #1;
    chk("post_rst_writes", 64'(nwr), 64'(0));
    chk("post_rst_no_done", 64'(done_cyc == -1), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
